// File: rtl/direct_interc_pipe.sv
// ---------------------------------------------------------------------------
// direct_interc_pipe
//
// Configurable point-to-point interconnect. A 2-bit mode word, loaded serially
// through the configuration chain, selects the datapath behaviour:
//   0 BYPASS : out = in, out_valid = in_valid (combinational)
//   1 PIPE   : DEPTH-stage shift register for data and valid, no stall
//   2 HOLD   : capture register, loads on in_valid, holds otherwise
//   3 OFF    : out = 0, out_valid = 0
// While config_enable is high the chain shifts, and the datapath is flushed:
// outputs are gated to 0 immediately and all stages clear at the next edge.
//
// Ports
//   clk           fabric clock, all state on rising edge
//   resetb        asynchronous active-low reset
//   config_enable 1 = chain shifts, datapath flushed
//   ccff_head     configuration chain serial input
//   ccff_tail     configuration chain serial output (mode[1], registered)
//   in/in_valid   WIDTH-bit data in and its qualifier
//   out/out_valid WIDTH-bit data out and its qualifier
// ---------------------------------------------------------------------------
module direct_interc_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             config_enable,
    input  logic             ccff_head,
    output logic             ccff_tail,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_PIPE   = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    logic [1:0]       mode_reg;
    logic [WIDTH-1:0] s_reg  [DEPTH];
    logic [WIDTH-1:0] s_next [DEPTH];
    logic [DEPTH-1:0] v_reg;
    logic [DEPTH-1:0] v_next;

    logic run_pipe;
    logic run_hold;

    // Stages only carry state in PIPE (all stages) and HOLD (stage 0);
    // everything else, and any cycle with config_enable, clears them.
    assign run_pipe = !config_enable && (mode_reg == MODE_PIPE);
    assign run_hold = !config_enable && (mode_reg == MODE_HOLD);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // In HOLD, v_reg[0] doubles as the "loaded at least once" flag.
                assign s_next[gi] = run_pipe              ? in :
                                    (run_hold && in_valid) ? in :
                                    run_hold              ? s_reg[gi] : '0;
                assign v_next[gi] = run_pipe ? in_valid :
                                    run_hold ? (v_reg[gi] | in_valid) : 1'b0;
            end else begin : g_tail
                assign s_next[gi] = run_pipe ? s_reg[gi-1] : '0;
                assign v_next[gi] = run_pipe ? v_reg[gi-1] : 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mode_reg <= MODE_BYPASS;
            v_reg    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                s_reg[k] <= '0;
            end
        end else begin
            // First bit shifted in ends up in mode[1] after two edges.
            if (config_enable) begin
                mode_reg <= {mode_reg[0], ccff_head};
            end
            v_reg <= v_next;
            for (int k = 0; k < DEPTH; k++) begin
                s_reg[k] <= s_next[k];
            end
        end
    end

    assign ccff_tail = mode_reg[1];

    // Output gating on resetb and config_enable is combinational so the bypass
    // path cannot leak data during reset or while the chain is reloading.
    always_comb begin
        out       = '0;
        out_valid = 1'b0;
        if (resetb && !config_enable) begin
            case (mode_reg)
                MODE_BYPASS: begin
                    out       = in;
                    out_valid = in_valid;
                end
                MODE_PIPE: begin
                    out       = s_reg[DEPTH-1];
                    out_valid = v_reg[DEPTH-1];
                end
                MODE_HOLD: begin
                    out       = s_reg[0];
                    out_valid = v_reg[0];
                end
                default: begin
                    out       = '0;
                    out_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_direct_interc_pipe.sv
module tb_direct_interc_pipe;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         resetb;
    logic         config_enable;
    logic         ccff_head;
    logic         ccff_tail;
    logic [W-1:0] din;
    logic         din_valid;
    logic [W-1:0] dout;
    logic         dout_valid;

    int checks = 0;
    int errors = 0;

    // Pipeline reference: a queue of the last D (data, valid) inputs.
    logic [W-1:0] pq_d [$];
    logic         pq_v [$];

    always #5 clk = ~clk;

    direct_interc_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .config_enable(config_enable),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .in           (din),
        .in_valid     (din_valid),
        .out          (dout),
        .out_valid    (dout_valid)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift a 2-bit mode word through the chain; m[1] goes first.
    task automatic load_mode(input logic [1:0] m);
        config_enable = 1'b1;
        ccff_head     = m[1];
        tick();
        ccff_head     = m[0];
        tick();
        config_enable = 1'b0;
        ccff_head     = 1'b0;
    endtask

    task automatic pipe_model_flush();
        pq_d.delete();
        pq_v.delete();
        for (int i = 0; i < D; i++) begin
            pq_d.push_back('0);
            pq_v.push_back(1'b0);
        end
    endtask

    task automatic pipe_model_edge();
        void'(pq_d.pop_front());
        void'(pq_v.pop_front());
        pq_d.push_back(din);
        pq_v.push_back(din_valid);
    endtask

    task automatic test_reset();
        resetb = 1'b0; config_enable = 1'b0; ccff_head = 1'b0;
        din = 8'h01; din_valid = 1'b1;
        #3;
        checks++;
        if (dout !== 8'h00 || dout_valid !== 1'b0 || ccff_tail !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h valid=%b tail=%b, required 00 0 0", dout, dout_valid, ccff_tail);
        end
        resetb = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h01 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_bypass: out=%h valid=%b, required 01 1", dout, dout_valid);
        end
        $display("reset: out=%h valid=%b tail=%b", dout, dout_valid, ccff_tail);
        tick();
    endtask

    task automatic test_chain_and_off();
        din = 8'h5C; din_valid = 1'b1;
        config_enable = 1'b1; ccff_head = 1'b0;
        #3;
        checks++;
        if (dout !== 8'h00 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL chain_gate: out=%h valid=%b, required 00 0", dout, dout_valid);
        end
        tick();
        checks++;
        if (ccff_tail !== 1'b0) begin
            errors++;
            $display("FAIL chain_tail1: tail=%b, required 0", ccff_tail);
        end
        ccff_head = 1'b1;
        tick();
        checks++;
        if (ccff_tail !== 1'b0) begin
            errors++;
            $display("FAIL chain_tail2: tail=%b, required 0", ccff_tail);
        end
        tick();
        checks++;
        if (ccff_tail !== 1'b1) begin
            errors++;
            $display("FAIL chain_tail3: tail=%b, required 1", ccff_tail);
        end
        $display("chain: mode 11 loaded, tail=%b", ccff_tail);
        config_enable = 1'b0; ccff_head = 1'b0;
        for (int c = 0; c < 8; c++) begin
            din = W'($urandom); din_valid = 1'($urandom);
            #3;
            checks++;
            if (dout !== 8'h00 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL off_c%0d: out=%h valid=%b, required 00 0", c, dout, dout_valid);
            end
            $display("off: in=%h iv=%b out=%h ov=%b", din, din_valid, dout, dout_valid);
            tick();
        end
    endtask

    task automatic test_bypass();
        load_mode(2'd0);
        for (int c = 0; c < 10; c++) begin
            din = W'($urandom); din_valid = 1'($urandom);
            config_enable = (c == 6);   // head=0 keeps the mode at bypass
            #3;
            checks++;
            if (config_enable) begin
                if (dout !== 8'h00 || dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bypass_flush_c%0d: out=%h valid=%b, required 00 0", c, dout, dout_valid);
                end
            end else if (dout !== din || dout_valid !== din_valid) begin
                errors++;
                $display("FAIL bypass_c%0d: out=%h valid=%b, required %h %b", c, dout, dout_valid, din, din_valid);
            end
            $display("bypass: in=%h iv=%b ce=%b out=%h ov=%b", din, din_valid, config_enable, dout, dout_valid);
            tick();
        end
        config_enable = 1'b0;
    endtask

    task automatic test_pipe();
        logic [7:0] td [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       tv [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] ed [8] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        logic       ev [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        load_mode(2'd1);
        for (int c = 0; c < 8; c++) begin
            din = td[c]; din_valid = tv[c];
            #3;
            checks++;
            if (dout !== ed[c] || dout_valid !== ev[c]) begin
                errors++;
                $display("FAIL pipe_dir_c%0d: out=%h valid=%b, required %h %b", c, dout, dout_valid, ed[c], ev[c]);
            end
            $display("pipe: c%0d in=%h iv=%b out=%h ov=%b", c, din, din_valid, dout, dout_valid);
            tick();
        end
        // Random stream, fresh flush so the reference starts from empty stages.
        load_mode(2'd1);
        pipe_model_flush();
        for (int c = 0; c < 40; c++) begin
            din = W'($urandom); din_valid = 1'($urandom);
            #3;
            checks++;
            if (dout !== pq_d[0] || dout_valid !== pq_v[0]) begin
                errors++;
                $display("FAIL pipe_rand_c%0d: out=%h valid=%b, required %h %b", c, dout, dout_valid, pq_d[0], pq_v[0]);
            end
            $display("pipe_rand: in=%h iv=%b out=%h ov=%b", din, din_valid, dout, dout_valid);
            pipe_model_edge();
            tick();
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] held;
        logic         loaded;
        load_mode(2'd2);
        held = '0; loaded = 1'b0;
        for (int c = 0; c < 36; c++) begin
            if (c == 0)      begin din = 8'hA5; din_valid = 1'b1; end
            else if (c < 5)  begin din = 8'h5A; din_valid = 1'b0; end
            else if (c == 5) begin din = 8'h5A; din_valid = 1'b1; end
            else             begin din = W'($urandom); din_valid = ($urandom_range(0, 3) == 0); end
            #3;
            checks++;
            if (dout !== held || dout_valid !== loaded) begin
                errors++;
                $display("FAIL hold_c%0d: out=%h valid=%b, required %h %b", c, dout, dout_valid, held, loaded);
            end
            if (c == 6) begin
                checks++;
                if (dout !== 8'h5A) begin
                    errors++;
                    $display("FAIL hold_reload: out=%h, required 5a", dout);
                end
            end
            $display("hold: c%0d in=%h iv=%b out=%h ov=%b", c, din, din_valid, dout, dout_valid);
            if (din_valid) begin
                held = din; loaded = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_flush();
        load_mode(2'd1);
        din = 8'hC1; din_valid = 1'b1; tick();
        din = 8'hC2; tick();
        din = 8'hC3; tick();
        din = 8'h00; din_valid = 1'b0;
        config_enable = 1'b1; ccff_head = 1'b0;
        #3;
        checks++;
        if (dout !== 8'h00 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_gate: out=%h valid=%b, required 00 0", dout, dout_valid);
        end
        tick();
        ccff_head = 1'b1;
        tick();
        config_enable = 1'b0; ccff_head = 1'b0;
        for (int c = 0; c < 2 * D; c++) begin
            #3;
            checks++;
            if (dout !== 8'h00 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale_c%0d: out=%h valid=%b, required 00 0", c, dout, dout_valid);
            end
            $display("flush: c%0d out=%h ov=%b", c, dout, dout_valid);
            tick();
        end
    endtask

    task automatic test_async_reset();
        load_mode(2'd1);
        for (int c = 0; c < 3; c++) begin
            din = W'($urandom_range(1, 255)); din_valid = 1'b1;
            tick();
        end
        din = 8'hFF; din_valid = 1'b1;
        #1;
        resetb = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || dout_valid !== 1'b0 || ccff_tail !== 1'b0) begin
            errors++;
            $display("FAIL areset_gate: out=%h valid=%b tail=%b, required 00 0 0", dout, dout_valid, ccff_tail);
        end
        resetb = 1'b1;
        #1;
        checks++;
        if (dout !== din || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_bypass: out=%h valid=%b, required %h 1", dout, dout_valid, din);
        end
        $display("areset: out=%h ov=%b tail=%b", dout, dout_valid, ccff_tail);
        tick();
        for (int c = 0; c < 4; c++) begin
            din = W'($urandom); din_valid = 1'($urandom);
            #3;
            checks++;
            if (dout !== din || dout_valid !== din_valid) begin
                errors++;
                $display("FAIL areset_after_c%0d: out=%h valid=%b, required %h %b", c, dout, dout_valid, din, din_valid);
            end
            $display("areset_after: in=%h iv=%b out=%h ov=%b", din, din_valid, dout, dout_valid);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_chain_and_off();
        test_bypass();
        test_pipe();
        test_hold();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
